param_xfer_sched: RTL and testbench
===================================

Name: param_xfer_sched

Overview:
- Schedules the PROM-to-FIFO parameter transfer engine and the FIFO readback path between two requesters: the auto-load sequencer (req 0) and the JTAG/user-command readback (req 1).
- Per granted job, in CLK40 domain: latch mode, pulse PROM2FF, wait for transfer-done (from CLK20 domain) with timeout, issue N PF_RD strobes, report done or error.
- Sits between the requesters and the transfer/readback datapath, replacing the ORed PROM2FF/PF_RD drive.

Parameters:
- MAX_WRDS, 9'd34, readback word count used when the latched NWRDS is 0.
- TMO_W, 16, width of the transfer-done timeout counter; timeout occurs at all-ones.
- P2F_LEN, 3, PROM2FF pulse length in CLK40 cycles (at least 2, so CLK20 samples it).
- RD_GAP, 2, idle CLK40 cycles after each PF_RD strobe. Covers the FIFO read and downstream decode pipeline.

Ports:
- CLK40, in, 1, 40 MHz clock.
- RST_B, in, 1, asynchronous active-low reset.
- REQ, in, 2, level requests; [0] = auto-load, [1] = JTAG.
- MODE0, in, 3, {DECODE, CRC, ECC} for req 0, sampled at grant.
- MODE1, in, 3, {DECODE, CRC, ECC} for req 1, sampled at grant.
- NWRDS0, in, 9, readback count for req 0; 0 selects MAX_WRDS.
- NWRDS1, in, 9, readback count for req 1; 0 selects MAX_WRDS.
- XFER_DONE, in, 1, transfer-engine done; asynchronous to CLK40.
- PF_MT, in, 1, parameter FIFO empty.
- GNT, out, 2, one-hot grant, held for the whole job.
- PROM2FF, out, 1, transfer start pulse.
- ECC, out, 1, latched mode bit, held while granted.
- CRC, out, 1, latched mode bit, held while granted.
- DECODE, out, 1, latched mode bit, held while granted.
- PF_RD, out, 1, single-cycle FIFO read strobe.
- DONE, out, 2, one-cycle completion pulse to the owning requester.
- ERR, out, 2, one-cycle error pulse to the owning requester.
- ERR_CODE, out, 2, 01 = timeout, 10 = underflow; held until the next grant.
- WRD_CNT, out, 9, count of PF_RD strobes issued in the current job.
- SCHED_STATE, out, 3, state encoding for debug.

Behaviour:
- Reset (RST_B low, asynchronous): all outputs 0, state IDLE, round-robin pointer = req 0.
- XFER_DONE path: 2-flop synchronizer, then rising-edge detect. An edge is acknowledged only in WAIT_XF; edges seen in any other state are ignored.

State machine:
- IDLE:
  - No request: stay.
  - One request: grant it.
  - Both requests: grant the one the pointer names.
  - On grant, in the next cycle: GNT is set; ECC/CRC/DECODE and the word target are latched; WRD_CNT and the timeout counter are cleared. Go to START.
- START: PROM2FF high for exactly P2F_LEN cycles, then go to WAIT_XF.
- WAIT_XF:
  - Timeout counter increments each cycle.
  - Synced XFER_DONE edge: go to READ.
  - Counter reaches all-ones first: ERR_CODE=01, go to FAIL.
- READ:
  - WRD_CNT == target: go to FINISH.
  - Else PF_MT=1: ERR_CODE=10, go to FAIL.
  - Else: PF_RD=1 for one cycle, WRD_CNT increments, go to GAP.
- GAP: wait RD_GAP cycles, then go to READ.
- FINISH: DONE[owner] pulses 1 cycle; GNT clears in the same cycle; pointer moves to the other requester; go to IDLE.
- FAIL: ERR[owner] pulses 1 cycle; GNT clears; pointer moves; go to IDLE.

Job and request rules:
- Requests are sampled only in IDLE. Dropping REQ mid-job does not abort the job; the job completes or fails normally.
- A requester still asserting REQ after its DONE/ERR is re-arbitrated. There is a minimum of 1 IDLE cycle between jobs.
- Latched mode bits do not change while a grant is held, even if MODE inputs change.

Latency and sizing:
- Request to PROM2FF rising edge: 2 cycles.
- Minimum job length: 2 + P2F_LEN + XFER latency + target*(1+RD_GAP) + 2 cycles.
- WRD_CNT is 9 bits; target is at most 511, so it never wraps.

Decomposition:
- Shared package param_xfer_pkg holds:
  - state encodings;
  - ERR_CODE values;
  - requester indices AL_REQ_IDX=0 and JTAG_REQ_IDX=1;
  - default MAX_WRDS.
- One sub-module, param_sync_edge: 2-flop synchronizer plus rising-edge detector, async active-low reset. It is reused for the XFER_DONE crossing.

Test Plan:
- Single job: REQ=01, NWRDS0=0, MODE0=3'b011; XFER_DONE rises 40 cycles after PROM2FF.
  - GNT=01 and PROM2FF high 3 cycles.
  - 34 PF_RD pulses spaced 3 cycles apart.
  - DONE=01 once; WRD_CNT=34; ECC=CRC=1 and DECODE=0 throughout.
- Contention: REQ=11 held from reset.
  - Grants alternate 01, 10, 01.
  - At least 1 IDLE cycle between jobs; GNT never has two bits set.
- Timeout: REQ=10 with XFER_DONE never asserted.
  - After 2^TMO_W-1 WAIT_XF cycles: ERR=10 pulse, ERR_CODE=01, no PF_RD issued.
- Underflow: NWRDS1=10, with PF_MT going high after 4 reads.
  - Exactly 4 PF_RD pulses, then ERR=10 and ERR_CODE=10.
- Mid-job disturbances: REQ drops and MODE0 changes during WAIT_XF.
  - The job completes with DONE=01 and the latched mode is unchanged.
  - A stray XFER_DONE edge in IDLE does not start or shorten the next job.
- Reset mid-job: RST_B low during GAP.
  - All outputs 0 immediately, asynchronously; state IDLE.
  - After release, a fresh job runs correctly.

Source files
------------

// File: rtl/param_xfer_pkg.sv
// Shared definitions for the parameter transfer scheduler: state and error
// encodings, requester indices and the default readback word count.
package param_xfer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_WAIT_XF = 3'd2,
        ST_READ    = 3'd3,
        ST_GAP     = 3'd4,
        ST_FINISH  = 3'd5,
        ST_FAIL    = 3'd6
    } sched_state_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'b00,
        ERR_TIMEOUT   = 2'b01,
        ERR_UNDERFLOW = 2'b10
    } err_code_e;

    localparam int AL_REQ_IDX   = 0;
    localparam int JTAG_REQ_IDX = 1;

    localparam logic [8:0] DEF_MAX_WRDS = 9'd34;

    // A requested count of zero means "read the full parameter block".
    function automatic logic [8:0] word_target(input logic [8:0] nwrds,
                                               input logic [8:0] max_wrds);
        return (nwrds == 9'd0) ? max_wrds : nwrds;
    endfunction

endpackage

// File: rtl/param_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector, used to bring
// the transfer-engine done level into the CLK40 domain as a one-cycle pulse.
module param_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], async_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/param_xfer_sched.sv
// Round-robin scheduler for the PROM-to-FIFO transfer engine and the FIFO
// readback path, shared by the auto-load sequencer and JTAG readback.
module param_xfer_sched
    import param_xfer_pkg::*;
#(
    parameter logic [8:0] MAX_WRDS = DEF_MAX_WRDS,
    parameter int         TMO_W    = 16,
    parameter int         P2F_LEN  = 3,
    parameter int         RD_GAP   = 2
) (
    input  logic       CLK40,
    input  logic       RST_B,
    input  logic [1:0] REQ,
    input  logic [2:0] MODE0,
    input  logic [2:0] MODE1,
    input  logic [8:0] NWRDS0,
    input  logic [8:0] NWRDS1,
    input  logic       XFER_DONE,
    input  logic       PF_MT,
    output logic [1:0] GNT,
    output logic       PROM2FF,
    output logic       ECC,
    output logic       CRC,
    output logic       DECODE,
    output logic       PF_RD,
    output logic [1:0] DONE,
    output logic [1:0] ERR,
    output logic [1:0] ERR_CODE,
    output logic [8:0] WRD_CNT,
    output logic [2:0] SCHED_STATE
);

    localparam int STEP_W = 8;
    localparam logic [STEP_W-1:0] P2F_LEN_C  = STEP_W'(P2F_LEN);
    localparam logic [STEP_W-1:0] GAP_LAST_C = STEP_W'(RD_GAP - 1);

    sched_state_e      state_q, state_d;
    err_code_e         err_code_q, err_code_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [2:0]        mode_q, mode_d;
    logic [8:0]        target_q, target_d;
    logic [8:0]        wrd_cnt_q, wrd_cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              ptr_q, ptr_d;
    logic              prom2ff_q, prom2ff_d;
    logic              pf_rd_q, pf_rd_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic              sel;
    logic              xfer_edge;

    param_sync_edge u_xfer_sync (
        .clk      (CLK40),
        .rst_n    (RST_B),
        .async_in (XFER_DONE),
        .rise     (xfer_edge)
    );

    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        gnt_d      = gnt_q;
        mode_d     = mode_q;
        target_d   = target_q;
        wrd_cnt_d  = wrd_cnt_q;
        tmo_d      = tmo_q;
        step_d     = step_q;
        ptr_d      = ptr_q;
        prom2ff_d  = 1'b0;
        pf_rd_d    = 1'b0;
        done_d     = 2'b00;
        err_d      = 2'b00;
        sel        = (REQ == 2'b11) ? ptr_q : REQ[JTAG_REQ_IDX];

        case (state_q)
            ST_IDLE: begin
                if (REQ != 2'b00) begin
                    gnt_d      = 2'b00;
                    gnt_d[sel ? JTAG_REQ_IDX : AL_REQ_IDX] = 1'b1;
                    mode_d     = sel ? MODE1 : MODE0;
                    target_d   = word_target(sel ? NWRDS1 : NWRDS0, MAX_WRDS);
                    wrd_cnt_d  = 9'd0;
                    tmo_d      = '0;
                    step_d     = '0;
                    err_code_d = ERR_NONE;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (step_q < P2F_LEN_C) begin
                    prom2ff_d = 1'b1;
                    step_d    = step_q + 1'b1;
                end else begin
                    step_d  = '0;
                    state_d = ST_WAIT_XF;
                end
            end
            ST_WAIT_XF: begin
                // A done edge wins over a timeout landing in the same cycle.
                if (xfer_edge) begin
                    state_d = ST_READ;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (&tmo_d) begin
                        err_code_d = ERR_TIMEOUT;
                        state_d    = ST_FAIL;
                    end
                end
            end
            ST_READ: begin
                if (wrd_cnt_q == target_q) begin
                    state_d = ST_FINISH;
                end else if (PF_MT) begin
                    err_code_d = ERR_UNDERFLOW;
                    state_d    = ST_FAIL;
                end else begin
                    pf_rd_d   = 1'b1;
                    wrd_cnt_d = wrd_cnt_q + 1'b1;
                    step_d    = '0;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (step_q >= GAP_LAST_C) begin
                    step_d  = '0;
                    state_d = ST_READ;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            ST_FINISH, ST_FAIL: begin
                if (state_q == ST_FINISH) begin
                    done_d = gnt_q;
                end else begin
                    err_d = gnt_q;
                end
                ptr_d   = gnt_q[AL_REQ_IDX];
                gnt_d   = 2'b00;
                mode_d  = 3'b000;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK40 or negedge RST_B) begin
        if (!RST_B) begin
            state_q    <= ST_IDLE;
            err_code_q <= ERR_NONE;
            gnt_q      <= 2'b00;
            mode_q     <= 3'b000;
            target_q   <= 9'd0;
            wrd_cnt_q  <= 9'd0;
            tmo_q      <= '0;
            step_q     <= '0;
            ptr_q      <= 1'b0;
            prom2ff_q  <= 1'b0;
            pf_rd_q    <= 1'b0;
            done_q     <= 2'b00;
            err_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
            gnt_q      <= gnt_d;
            mode_q     <= mode_d;
            target_q   <= target_d;
            wrd_cnt_q  <= wrd_cnt_d;
            tmo_q      <= tmo_d;
            step_q     <= step_d;
            ptr_q      <= ptr_d;
            prom2ff_q  <= prom2ff_d;
            pf_rd_q    <= pf_rd_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign GNT                = gnt_q;
    assign PROM2FF            = prom2ff_q;
    assign {DECODE, CRC, ECC} = mode_q;
    assign PF_RD              = pf_rd_q;
    assign DONE               = done_q;
    assign ERR                = err_q;
    assign ERR_CODE           = err_code_q;
    assign WRD_CNT            = wrd_cnt_q;
    assign SCHED_STATE        = state_q;

endmodule

// File: tb/tb_param_xfer_sched.sv
// Directed and randomized jobs against a job-level reference model of the
// scheduler: grant order, pulse lengths, read counts and job outcome.
module tb_param_xfer_sched;
    import param_xfer_pkg::*;

    localparam int TMO_W   = 8;
    localparam int TMO_CYC = (1 << TMO_W) - 1;

    logic       CLK40 = 1'b0;
    logic       RST_B;
    logic [1:0] REQ;
    logic [2:0] MODE0, MODE1;
    logic [8:0] NWRDS0, NWRDS1;
    logic       XFER_DONE, PF_MT;
    logic [1:0] GNT, DONE, ERR, ERR_CODE;
    logic       PROM2FF, ECC, CRC, DECODE, PF_RD;
    logic [8:0] WRD_CNT;
    logic [2:0] SCHED_STATE;

    int total = 0;
    int bad   = 0;
    bit rr_ptr;

    param_xfer_sched #(.TMO_W(TMO_W)) dut (
        .CLK40(CLK40), .RST_B(RST_B), .REQ(REQ), .MODE0(MODE0), .MODE1(MODE1),
        .NWRDS0(NWRDS0), .NWRDS1(NWRDS1), .XFER_DONE(XFER_DONE), .PF_MT(PF_MT),
        .GNT(GNT), .PROM2FF(PROM2FF), .ECC(ECC), .CRC(CRC), .DECODE(DECODE),
        .PF_RD(PF_RD), .DONE(DONE), .ERR(ERR), .ERR_CODE(ERR_CODE),
        .WRD_CNT(WRD_CNT), .SCHED_STATE(SCHED_STATE)
    );

    always #5 CLK40 = ~CLK40;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One job from request to DONE/ERR; the FIFO holds 'avail' words and the
    // transfer engine answers 'xf_lat' cycles after PROM2FF drops.
    task automatic apply_job(input logic [1:0] req_mask, input bit hold_req, input int avail,
                             input int xf_lat, input bit give_done, input bit disturb,
                             input bit abort_gap);
        int owner, target, exp_reads, exp_code;
        int cyc = 0, gnt_at = 0, p2f_first = 0, p2f_cnt = 0, reads = 0, last_rd = 0;
        int spacing_bad = 0, mode_bad = 0, onehot_bad = 0, wait_cyc = 0, xf_cnt = 0;
        bit fell = 0, finished = 0, exp_ok;
        logic [1:0] exp_gnt, gnt_val = 2'b00, got_done = 2'b00, got_err = 2'b00;
        logic [2:0] exp_mode;
        logic [8:0] nw;

        owner     = (req_mask == 2'b11) ? int'(rr_ptr) : (req_mask[1] ? 1 : 0);
        exp_gnt   = (owner == 1) ? 2'b10 : 2'b01;
        exp_mode  = (owner == 1) ? MODE1 : MODE0;
        nw        = (owner == 1) ? NWRDS1 : NWRDS0;
        target    = (nw == 0) ? 34 : int'(nw);
        exp_ok    = give_done && (avail >= target);
        exp_reads = !give_done ? 0 : ((avail < target) ? avail : target);
        exp_code  = !give_done ? 1 : (exp_ok ? 0 : 2);

        REQ   = req_mask;
        PF_MT = (avail == 0);
        while (!finished && cyc < 2000) begin
            @(negedge CLK40);
            cyc++;
            if (GNT == 2'b11) onehot_bad++;
            if (GNT != 2'b00 && gnt_at == 0) begin
                gnt_at  = cyc;
                gnt_val = GNT;
                if (!hold_req) REQ = 2'b00;
            end
            if (GNT != 2'b00 && {DECODE, CRC, ECC} !== exp_mode) mode_bad++;
            if (PROM2FF) begin
                if (p2f_first == 0) p2f_first = cyc;
                p2f_cnt++;
            end else if (p2f_cnt > 0 && !fell) begin
                fell = 1;
            end
            if (SCHED_STATE == ST_WAIT_XF) begin
                wait_cyc++;
                if (disturb && wait_cyc == 1) begin
                    REQ   = 2'b00;
                    MODE0 = ~MODE0;
                    MODE1 = ~MODE1;
                end
            end
            if (fell && give_done) begin
                if (xf_cnt == xf_lat) XFER_DONE = 1'b1;
                if (xf_cnt == xf_lat + 4) XFER_DONE = 1'b0;
                xf_cnt++;
            end
            if (PF_RD) begin
                if (reads > 0 && cyc - last_rd != 3) spacing_bad++;
                last_rd = cyc;
                reads++;
            end
            PF_MT = (reads >= avail);
            if (abort_gap && SCHED_STATE == ST_GAP) begin
                #2 RST_B = 1'b0;
                #1;
                check_output("async_reset_outs", {GNT, PROM2FF, ECC, CRC, DECODE, PF_RD, DONE, ERR,
                                                  ERR_CODE, WRD_CNT}, 0);
                check_output("async_reset_state", SCHED_STATE, ST_IDLE);
                return;
            end
            if (DONE != 2'b00 || ERR != 2'b00) begin
                finished = 1;
                got_done = DONE;
                got_err  = ERR;
            end
        end

        check_output("job_finished", finished, 1);
        check_output("gnt_owner", gnt_val, exp_gnt);
        check_output("gnt_latency", gnt_at, 1);
        check_output("p2f_latency", p2f_first, 2);
        check_output("p2f_length", p2f_cnt, 3);
        check_output("read_count", reads, exp_reads);
        check_output("wrd_cnt", WRD_CNT, exp_reads);
        check_output("read_spacing", spacing_bad, 0);
        check_output("mode_held", mode_bad, 0);
        check_output("gnt_onehot", onehot_bad, 0);
        check_output("done_pulse", got_done, exp_ok ? exp_gnt : 2'b00);
        check_output("err_pulse", got_err, exp_ok ? 2'b00 : exp_gnt);
        check_output("err_code", ERR_CODE, exp_code);
        check_output("gnt_released", GNT, 0);
        if (give_done)
            check_output("wait_window", (wait_cyc >= xf_lat + 1) && (wait_cyc <= xf_lat + 5), 1);
        else
            check_output("timeout_wait", wait_cyc, TMO_CYC);
        rr_ptr    = (owner == 0);
        XFER_DONE = 1'b0;
        PF_MT     = 1'b0;
    endtask

    initial begin
        int mask, avail;
        RST_B = 1'b0; REQ = 2'b00; MODE0 = 3'b000; MODE1 = 3'b000;
        NWRDS0 = 9'd0; NWRDS1 = 9'd0; XFER_DONE = 1'b0; PF_MT = 1'b0;
        repeat (3) @(negedge CLK40);
        check_output("reset_outs", {GNT, PROM2FF, ECC, CRC, DECODE, PF_RD, DONE, ERR,
                                    ERR_CODE, WRD_CNT}, 0);
        check_output("reset_state", SCHED_STATE, ST_IDLE);
        RST_B = 1'b1;
        rr_ptr = 1'b0;
        @(negedge CLK40);

        $display("[TB] single auto-load job, full block");
        MODE0 = 3'b011; NWRDS0 = 9'd0;
        apply_job(2'b01, 0, 512, 40, 1, 0, 0);

        $display("[TB] contention from reset");
        RST_B = 1'b0; REQ = 2'b11;
        MODE0 = 3'b110; MODE1 = 3'b001; NWRDS0 = 9'd3; NWRDS1 = 9'd2;
        @(negedge CLK40);
        RST_B = 1'b1;
        rr_ptr = 1'b0;
        for (int j = 0; j < 3; j++) apply_job(2'b11, 1, 512, 10, 1, 0, 0);
        REQ = 2'b00;

        $display("[TB] transfer timeout on JTAG job");
        NWRDS1 = 9'd5;
        apply_job(2'b10, 0, 512, 0, 0, 0, 0);

        $display("[TB] FIFO underflow on JTAG job");
        NWRDS1 = 9'd10;
        apply_job(2'b10, 0, 4, 20, 1, 0, 0);

        $display("[TB] stray done edge in idle, then disturbed job");
        XFER_DONE = 1'b1;
        repeat (4) @(negedge CLK40);
        XFER_DONE = 1'b0;
        repeat (4) @(negedge CLK40);
        check_output("stray_idle_state", SCHED_STATE, ST_IDLE);
        check_output("stray_idle_gnt", GNT, 0);
        MODE0 = 3'b101; NWRDS0 = 9'd4;
        apply_job(2'b01, 0, 512, 25, 1, 1, 0);

        $display("[TB] reset during read gap, then fresh job");
        NWRDS0 = 9'd6;
        apply_job(2'b01, 0, 512, 10, 1, 0, 1);
        @(negedge CLK40);
        REQ = 2'b00; XFER_DONE = 1'b0; PF_MT = 1'b0;
        RST_B = 1'b1;
        rr_ptr = 1'b0;
        MODE1 = 3'b111; NWRDS1 = 9'd3;
        apply_job(2'b10, 0, 512, 12, 1, 0, 0);

        $display("[TB] randomized jobs");
        for (int j = 0; j < 8; j++) begin
            mask   = int'($urandom_range(1, 3));
            MODE0  = 3'($urandom);
            MODE1  = 3'($urandom);
            NWRDS0 = 9'($urandom_range(0, 8));
            NWRDS1 = 9'($urandom_range(0, 8));
            avail  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : 512;
            apply_job(2'(mask), 0, avail, int'($urandom_range(2, 40)), 1, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
